// File: rtl/ntt_intt_bfly_sched.sv
// Butterfly scheduler for one in-place NTT/INTT over 2**LOGN coefficients.
// Each RUN cycle issues one butterfly's operand read addresses and twiddle
// address. The write-back addresses are the read addresses delayed PIPE cycles.
// DRAIN holds off the next stage until that stage's last write has landed.
module ntt_intt_bfly_sched #(
  parameter int LOGN = 3,
  parameter int PIPE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            inv,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic            rd_en,
  output logic [LOGN-1:0] tf_addr,
  output logic            pe_inv,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b,
  output logic            wr_en
);

  localparam int BPS = 1 << (LOGN - 1);
  localparam int JW  = (LOGN > 1) ? LOGN - 1 : 1;
  localparam int SW  = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int DW  = (PIPE > 1) ? $clog2(PIPE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_s, w_s_nxt;
  logic [JW-1:0]   r_j, w_j_nxt;
  logic [DW-1:0]   r_d, w_d_nxt;
  logic            r_inv, w_inv_nxt;

  logic [LOGN-1:0] r_rd_a, r_rd_b, r_tf;
  logic            r_rd_en;

  logic [PIPE-1:0] r_dly_en;
  logic [LOGN-1:0] r_dly_a [PIPE];
  logic [LOGN-1:0] r_dly_b [PIPE];

  logic [SW-1:0]   w_e;
  logic [LOGN-1:0] w_jx, w_h, w_g, w_o, w_a, w_b, w_tf;

  // State register with stage, butterfly and drain counters and captured direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_j     <= '0;
      r_d     <= '0;
      r_inv   <= 1'b0;
    end else begin
      // NOTE: state elements use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_j     <= w_j_nxt;
      r_d     <= w_d_nxt;
      r_inv   <= w_inv_nxt;
    end
  end

  // Next-state logic: walk stages, butterflies within a stage, then drain.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_j_nxt     = r_j;
    w_d_nxt     = r_d;
    w_inv_nxt   = r_inv;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_s_nxt     = '0;
          w_j_nxt     = '0;
          w_inv_nxt   = inv;
        end
      end
      ST_RUN: begin
        if (r_j == JW'(BPS - 1)) begin
          w_state_nxt = ST_DRAIN;
          w_d_nxt     = '0;
        end else begin
          w_j_nxt = r_j + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_d == DW'(PIPE - 1)) begin
          if (r_s == SW'(LOGN - 1)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
            w_s_nxt     = r_s + 1'b1;
            w_j_nxt     = '0;
          end
        end else begin
          w_d_nxt = r_d + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_inv_nxt   = 1'b0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Butterfly addressing. With e = log2(half-span), forward uses e = LOGN-1-s
  // and inverse uses e = s; the twiddle base 2**(LOGN-1-e) is then common to both.
  always_comb begin
    w_e  = r_inv ? r_s : (SW'(LOGN - 1) - r_s);
    w_jx = LOGN'(r_j);
    w_h  = LOGN'(1) << w_e;
    w_g  = w_jx >> w_e;
    w_o  = w_jx & (w_h - LOGN'(1));
    w_a  = ((w_g << w_e) << 1) | w_o;
    w_b  = w_a + w_h;
    w_tf = (LOGN'(1) << (SW'(LOGN - 1) - w_e)) + w_g;
  end

  // Registered read-side outputs; addresses are zeroed outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_tf    <= '0;
    end else begin
      r_rd_en <= (r_state == ST_RUN);
      r_rd_a  <= (r_state == ST_RUN) ? w_a  : '0;
      r_rd_b  <= (r_state == ST_RUN) ? w_b  : '0;
      r_tf    <= (r_state == ST_RUN) ? w_tf : '0;
    end
  end

  // Write-back delay line carrying {rd_en, rd_addr_a, rd_addr_b} PIPE cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the delay line is reset entry by entry, so a reset drops in-flight
      // writes at once instead of replaying stale enables afterwards.
      r_dly_en <= '0;
      for (int i = 0; i < PIPE; i++) begin
        r_dly_a[i] <= '0;
        r_dly_b[i] <= '0;
      end
    end else begin
      r_dly_en[0] <= r_rd_en;
      r_dly_a[0]  <= r_rd_a;
      r_dly_b[0]  <= r_rd_b;
      for (int i = 1; i < PIPE; i++) begin
        r_dly_en[i] <= r_dly_en[i-1];
        r_dly_a[i]  <= r_dly_a[i-1];
        r_dly_b[i]  <= r_dly_b[i-1];
      end
    end
  end

  assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);
  assign pe_inv    = r_inv;
  assign rd_en     = r_rd_en;
  assign rd_addr_a = r_rd_a;
  assign rd_addr_b = r_rd_b;
  assign tf_addr   = r_tf;
  assign wr_en     = r_dly_en[PIPE-1];
  assign wr_addr_a = r_dly_a[PIPE-1];
  assign wr_addr_b = r_dly_b[PIPE-1];

endmodule

// File: tb/tb_ntt_intt_bfly_sched.sv
// Directed bench for ntt_intt_bfly_sched with LOGN=3 and PIPE=2.
// Cycle 0 is the cycle whose closing edge accepts start. The bench samples
// outputs on the falling edge of each cycle.
module tb_ntt_intt_bfly_sched;

  logic       clk;
  logic       rst;
  logic       start;
  logic       inv;
  logic       busy, done, rd_en, pe_inv, wr_en;
  logic [2:0] rd_addr_a, rd_addr_b, tf_addr, wr_addr_a, wr_addr_b;

  int total = 0;
  int bad   = 0;

  // Hand-derived butterfly sequences, stage-major, 4 butterflies per stage.
  int fwd_a  [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int fwd_b  [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int fwd_tf [12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
  int inv_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int inv_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int inv_tf [12] = '{4, 5, 6, 7, 2, 2, 3, 3, 1, 1, 1, 1};

  ntt_intt_bfly_sched #(.LOGN(3), .PIPE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inv       (inv),
    .busy      (busy),
    .done      (done),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_en     (rd_en),
    .tf_addr   (tf_addr),
    .pe_inv    (pe_inv),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .wr_en     (wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full transform from cycle 0 to the done cycle (19).
  // hold keeps start high throughout. poke pulses start at cycle 5 and flips inv at cycle 3.
  task automatic run_xform(input logic inv_val, input bit hold, input bit poke);
    int  rd_cnt, wr_cnt, viol, k, m;
    bit  rv, wv;
    rd_cnt = 0;
    wr_cnt = 0;
    viol   = 0;
    start  = 1'b1;
    inv    = inv_val;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (!hold && c == 1) start = 1'b0;
      if (poke && c == 3) inv = ~inv_val;
      if (poke && c == 5) start = 1'b1;
      if (poke && c == 6) start = 1'b0;

      rv = (c >= 2) && (c <= 17) && (((c - 2) % 6) < 4);
      wv = (c >= 4) && (c <= 19) && (((c - 4) % 6) < 4);
      k  = ((c - 2) / 6) * 4 + ((c - 2) % 6);
      m  = ((c - 4) / 6) * 4 + ((c - 4) % 6);

      check($sformatf("rd_en c%0d", c), rd_en, rv);
      if (rv) begin
        check($sformatf("rd_a c%0d", c), rd_addr_a, inv_val ? inv_a[k]  : fwd_a[k]);
        check($sformatf("rd_b c%0d", c), rd_addr_b, inv_val ? inv_b[k]  : fwd_b[k]);
        check($sformatf("tf c%0d", c),   tf_addr,   inv_val ? inv_tf[k] : fwd_tf[k]);
      end
      check($sformatf("wr_en c%0d", c), wr_en, wv);
      if (wv) begin
        check($sformatf("wr_a c%0d", c), wr_addr_a, inv_val ? inv_a[m] : fwd_a[m]);
        check($sformatf("wr_b c%0d", c), wr_addr_b, inv_val ? inv_b[m] : fwd_b[m]);
      end
      check($sformatf("busy c%0d", c), busy, (c <= 18));
      check($sformatf("done c%0d", c), done, (c == 19));
      if (c <= 18) check($sformatf("pe_inv c%0d", c), pe_inv, inv_val);

      // A read of stage s must not start before all 4 writes of stage s-1 have landed.
      if (rd_en === 1'b1) begin
        if (wr_cnt < 4 * (rd_cnt / 4)) viol++;
        rd_cnt++;
      end
      if (wr_en === 1'b1) wr_cnt++;
    end
    check("wr_pulses", wr_cnt, 12);
    check("rd_cnt", rd_cnt, 12);
    check("overlap", viol, 0);
    inv = inv_val;
  endtask

  initial begin
    int seen;
    rst   = 1'b1;
    start = 1'b0;
    inv   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst rd_en", rd_en, 0);
    check("rst wr_en", wr_en, 0);
    check("rst pe_inv", pe_inv, 0);
    check("rst tf", tf_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Forward transform. A start pulse at cycle 5 and an inv change at cycle 3 must not disturb it.
    run_xform(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("idle busy fwd", busy, 0);
    check("idle done fwd", done, 0);
    check("idle wr_en fwd", wr_en, 0);

    // Inverse transform.
    run_xform(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("idle busy inv", busy, 0);
    check("idle pe_inv", pe_inv, 0);

    // Back-to-back: start held high restarts from IDLE right after done.
    run_xform(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("b2b idle busy", busy, 0);
    check("b2b idle done", done, 0);
    run_xform(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("b2b end busy", busy, 0);
    @(negedge clk);
    check("b2b stop busy", busy, 0);

    // Asynchronous reset in the middle of an inverse run, while reads and writes are both active.
    start = 1'b1;
    inv   = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    check("pre-rst rd_en", rd_en, 1);
    check("pre-rst wr_en", wr_en, 1);
    #1 rst = 1'b1;
    #1;
    check("async busy", busy, 0);
    check("async done", done, 0);
    check("async rd_en", rd_en, 0);
    check("async wr_en", wr_en, 0);
    check("async pe_inv", pe_inv, 0);
    check("async rd_a", rd_addr_a, 0);
    check("async rd_b", rd_addr_b, 0);
    check("async tf", tf_addr, 0);
    check("async wr_a", wr_addr_a, 0);
    check("async wr_b", wr_addr_b, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("post-rst quiet", seen, 0);

    // Recovery: a fresh forward transform after reset runs normally.
    inv = 1'b0;
    run_xform(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
